// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller.
// Each digit owns a fixed slot of DIV cycles. The first BLANK_CYC cycles of
// every slot keep all anodes off to prevent ghosting. New display contents
// are staged in a one-entry pending buffer and applied only at frame
// boundaries, or immediately while the display is off, so a frame never tears.
//
// Update handshake: a transfer happens on any rising edge where
// upd_valid & upd_ready. The producer holds upd_data/upd_dig_en/upd_dp
// stable while upd_valid is high. upd_ready is low while the pending buffer
// is occupied.
module seg_scan_ctrl #(
   parameter int DIV       = 100000,
   parameter int BLANK_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        upd_valid,
   output logic        upd_ready,
   input  logic [31:0] upd_data,
   input  logic [7:0]  upd_dig_en,
   input  logic [7:0]  upd_dp,
   output logic [7:0]  AN,
   output logic        DP,
   output logic [3:0]  dig_code,
   output logic        frame_done
);

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   localparam logic [19:0] SLOT_LAST  = 20'(DIV - 1);
   localparam logic [19:0] BLANK_LAST = 20'(BLANK_CYC - 1);

   logic [1:0]  state;
   logic [19:0] cnt;
   logic [2:0]  idx;

   logic [31:0] act_data;
   logic [7:0]  act_en;
   logic [7:0]  act_dp;
   logic [31:0] pend_data;
   logic [7:0]  pend_en;
   logic [7:0]  pend_dp;
   logic        pend_full;

   logic slot_end;
   logic lit;
   logic accept;
   logic apply;

   assign slot_end   = (state == S_SHOW) && (cnt == SLOT_LAST);
   assign frame_done = slot_end && (idx == 3'd7);
   assign lit        = (state == S_SHOW) && act_en[idx];

   assign upd_ready = ~pend_full;
   assign accept    = upd_valid & ~pend_full;
   // Pending contents go live at a frame boundary, or at once while off.
   assign apply     = pend_full & (frame_done | (state == S_OFF));

   // Output decode: anode, decimal point and nibble only for a lit digit.
   always_comb begin
      AN       = 8'hFF;
      DP       = 1'b1;
      dig_code = 4'h0;
      if (lit) begin
         AN[idx]  = 1'b0;
         DP       = ~act_dp[idx];
         dig_code = act_data[{idx, 2'b00} +: 4];
      end
   end

   // Scan FSM: OFF -> BLANK -> SHOW -> BLANK ..., one slot per digit.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state <= S_OFF;
         cnt   <= 20'd0;
         idx   <= 3'd0;
      end else begin
         case (state)
            S_OFF: begin
               state <= S_BLANK;
               cnt   <= 20'd0;
               idx   <= 3'd0;
            end
            S_BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state <= S_SHOW;
               end
               cnt <= cnt + 20'd1;
            end
            S_SHOW: begin
               if (slot_end) begin
                  state <= S_BLANK;
                  cnt   <= 20'd0;
                  idx   <= idx + 3'd1;
               end else begin
                  cnt <= cnt + 20'd1;
               end
            end
            default: begin
               state <= S_OFF;
               cnt   <= 20'd0;
               idx   <= 3'd0;
            end
         endcase
      end
   end

   // Pending buffer capture and transfer to the active display registers.
   // accept needs an empty buffer and apply needs a full one, so they never
   // coincide; an update taken on a frame_done cycle waits a whole frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_full <= 1'b0;
         pend_data <= 32'h0;
         pend_en   <= 8'h00;
         pend_dp   <= 8'h00;
         act_data  <= 32'h0;
         act_en    <= 8'h00;
         act_dp    <= 8'h00;
      end else begin
         if (accept) begin
            pend_full <= 1'b1;
            pend_data <= upd_data;
            pend_en   <= upd_dig_en;
            pend_dp   <= upd_dp;
         end
         if (apply) begin
            pend_full <= 1'b0;
            act_data  <= pend_data;
            act_en    <= pend_en;
            act_dp    <= pend_dp;
         end
      end
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 100000, SHALL set clock cycles per digit slot (legal range BLANK_CYC+2 .. 2^20-1).
REQ-002 Parameter BLANK_CYC, default 16, SHALL set the anti-ghosting blank cycles at the start of each slot (legal range 1 .. DIV-2).
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 en  in  1  SHALL be the scan enable; 0 blanks the display.
REQ-006 upd_valid  in  1  SHALL be the update request.
REQ-007 upd_ready  out  1  SHALL indicate that the pending buffer is free.
REQ-008 upd_data  in  32  SHALL carry eight nibbles; nibble i = [4i+3:4i] belongs to digit i.
REQ-009 upd_dig_en  in  8  SHALL carry the per-digit enable mask.
REQ-010 upd_dp  in  8  SHALL carry the per-digit decimal point (1 = lit).
REQ-011 AN  out  8  SHALL be the active-low digit anodes.
REQ-012 DP  out  1  SHALL be the active-low decimal point.
REQ-013 dig_code  out  4  SHALL be the nibble of the current digit, driven to the existing decoder feeding HEX.
REQ-014 frame_done  out  1  SHALL be a one-cycle pulse at the end of each full 8-digit frame.

Function
REQ-015 The block SHALL implement an FSM with states OFF, BLANK and SHOW.
REQ-016 OFF: AN=8'hFF, DP=1, slot counter=0, digit index=0; go to BLANK when en=1.
REQ-017 BLANK: AN=8'hFF, DP=1; after BLANK_CYC cycles go to SHOW.
REQ-018 SHOW: for cycles BLANK_CYC..DIV-1 of the slot, AN[idx]=0 iff active dig_en[idx]=1 (all others 1); DP=~dp[idx] when digit enabled, else 1; dig_code=nibble idx.
REQ-019 At slot end the FSM SHALL return to BLANK with idx incremented mod 8 (7 wraps to 0); slot length SHALL be exactly DIV cycles.
REQ-020 Disabled digits SHALL keep their time slot (AN stays 1), so refresh rate and brightness are independent of the mask.
REQ-021 frame_done SHALL pulse high for one cycle on the last cycle of the idx=7 slot.
REQ-022 en=0 in any state SHALL force OFF on the next cycle; no frame_done pulse SHALL be issued for a partial frame.
REQ-023 An update SHALL transfer when upd_valid & upd_ready; upd_data/upd_dig_en/upd_dp SHALL be captured into a pending buffer and upd_ready SHALL go 0 the next cycle.
REQ-024 While scanning, the pending contents SHALL be copied into the active registers on the frame_done cycle; upd_ready SHALL return to 1 the following cycle.
REQ-025 In OFF, a pending update SHALL be copied on the cycle after acceptance.
REQ-026 An update accepted on a frame_done cycle SHALL be applied at the next frame boundary, never mid-frame.
REQ-027 The displayed values SHALL never change within a frame (no tearing).
REQ-028 dig_code SHALL be 4'h0 whenever AN=8'hFF.

Reset
REQ-029 rst=1 SHALL force state OFF, AN=8'hFF, DP=1, dig_code=0, frame_done=0, upd_ready=1, active and pending data=0, dig_en=8'h00, dp=8'h00, and clear the counters.
REQ-030 rst SHALL take priority over en and upd_valid; reset mid-frame SHALL discard the pending update.

Verification (DIV=8, BLANK_CYC=2)
REQ-031 Reset, then en=1 with update data=32'h76543210, dig_en=FF, dp=00 -> after the first frame boundary, each slot shows AN=FF for 2 cycles, then AN=~(1<<i) with dig_code=i for 6 cycles; frame_done recurs every 64 cycles.
REQ-032 dig_en=8'h05, dp=8'h04 -> AN=FE at idx0 and AN=FB at idx2 with DP=0 at idx2; AN=FF in every other slot; period unchanged.
REQ-033 Hold upd_valid with a second update mid-frame -> upd_ready=0 until the cycle after frame_done; the new data is first visible in the idx0 slot of the next frame; a third upd_valid is held off.
REQ-034 Drop en at idx=3 SHOW -> next cycle AN=FF, state OFF, no frame_done; re-raise en -> restart at idx0 BLANK.
REQ-035 Assert rst during idx=5 with an update pending -> all outputs take their reset values next cycle, pending is discarded, and upd_ready=1.
